// File: rtl/pulse_meter_pkg.sv
// Shared types and default parameters for the pulse_meter block.
package pulse_meter_pkg;

  localparam int NCNTR_DEFAULT       = 8;
  localparam int SYNC_STAGES_DEFAULT = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_e;

endpackage

// File: rtl/pulse_meter_sync_edge.sv
// Multi-stage synchronizer for an asynchronous input followed by an edge-detect
// flop that produces single-cycle rise/fall strobes.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic sig_in,
  output logic sig_sync,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], sig_in};
    prev_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign sig_sync = sync_q[STAGES-1];
  assign rise     = sig_sync & ~prev_q;
  assign fall     = ~sig_sync & prev_q;

endmodule

// File: rtl/pulse_meter.sv
// Measures the period and high time of an asynchronous pulse train in clk cycles.
// Define PULSE_METER_DUTY_EN to build the high-time measurement; otherwise high_time reads 0.
module pulse_meter
  import pulse_meter_pkg::*;
#(
  parameter int NCntr       = NCNTR_DEFAULT,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             sig_in,
  output logic [NCntr-1:0] period,
  output logic [NCntr-1:0] high_time,
  output logic             valid,
  output logic             ovf
);

  localparam logic [NCntr-1:0] CNT_MAX = '1;
  localparam logic [NCntr-1:0] CNT_ONE = NCntr'(1);

  state_e           state_q, state_d;
  logic [NCntr-1:0] cnt_q, cnt_d;
  logic [NCntr-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             sig_sync, rise, fall;
  logic             meas_done, meas_ovf;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_edge (
    .clk      (clk),
    .rstn     (rstn),
    .sig_in   (sig_in),
    .sig_sync (sig_sync),
    .rise     (rise),
    .fall     (fall)
  );

  assign meas_done = en && (state_q == MEASURE) && rise;
  assign meas_ovf  = en && (state_q == MEASURE) && !rise && (cnt_q == CNT_MAX);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = ARM;
        ARM:     if (rise) state_d = MEASURE;
        MEASURE: if (meas_ovf) state_d = ARM;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    period_d = period_q;
    valid_d  = 1'b0;
    ovf_d    = ovf_q;
    if (en && (state_q == ARM) && rise) begin
      cnt_d = CNT_ONE;
    end else if (meas_done) begin
      cnt_d    = CNT_ONE;
      period_d = cnt_q;
      valid_d  = 1'b1;
    end else if (en && (state_q == MEASURE) && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
    // A completed measurement clears any earlier overflow.
    if (meas_ovf) ovf_d = 1'b1;
    if (valid_d)  ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q    <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
    end
  end

  assign period = period_q;
  assign valid  = valid_q;
  assign ovf    = ovf_q;

`ifdef PULSE_METER_DUTY_EN
  logic [NCntr-1:0] hcnt_q, hcnt_d;
  logic [NCntr-1:0] shadow_q, shadow_d;
  logic [NCntr-1:0] high_q, high_d;
  logic             fell_q, fell_d;

  // Without a fall during the period the signal was high throughout, so high time equals period.
  always_comb begin
    hcnt_d   = hcnt_q;
    shadow_d = shadow_q;
    high_d   = high_q;
    fell_d   = fell_q;
    if (en && (state_q == ARM) && rise) begin
      hcnt_d = CNT_ONE;
      fell_d = 1'b0;
    end else if (meas_done) begin
      high_d = fell_q ? shadow_q : cnt_q;
      hcnt_d = CNT_ONE;
      fell_d = 1'b0;
    end else if (en && (state_q == MEASURE)) begin
      if (sig_sync && (hcnt_q != CNT_MAX)) hcnt_d = hcnt_q + 1'b1;
      if (fall) begin
        shadow_d = hcnt_q;
        fell_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hcnt_q   <= '0;
      shadow_q <= '0;
      high_q   <= '0;
      fell_q   <= 1'b0;
    end else begin
      hcnt_q   <= hcnt_d;
      shadow_q <= shadow_d;
      high_q   <= high_d;
      fell_q   <= fell_d;
    end
  end

  assign high_time = high_q;
`else
  logic unused_duty;
  assign unused_duty = sig_sync ^ fall;
  assign high_time   = '0;
`endif

endmodule

// File: tb/tb_pulse_meter.sv
// Self-checking bench for pulse_meter: directed scenarios plus random pulse trains
// scored against a cycle-level model of rising-edge spacing and high-sample counts.
module tb_pulse_meter;

  localparam int NCNTR = 8;
  localparam int MAXP  = (1 << NCNTR) - 1;

  logic             clk = 1'b0;
  logic             rstn, en, sig_in;
  logic [NCNTR-1:0] period, high_time;
  logic             valid, ovf;

  always #5 clk = ~clk;

  pulse_meter #(.NCntr(NCNTR), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .en        (en),
    .sig_in    (sig_in),
    .period    (period),
    .high_time (high_time),
    .valid     (valid),
    .ovf       (ovf)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a measurement is the gap between consecutive pin rises
  // seen while enabled, with high time = number of high samples in that gap.
  int   cyc = 0, last_rise = 0, high_cnt = 0;
  bit   have_last = 0;
  logic pin_prev = 1'b0;
  int   q_per[$];
  int   q_high[$];
  int   last_period = 0;

  always @(posedge clk) begin
    if (!rstn || !en) begin
      have_last = 0;
    end else if (sig_in && !pin_prev) begin
      if (have_last && (cyc - last_rise) <= MAXP) begin
        q_per.push_back(cyc - last_rise);
`ifdef PULSE_METER_DUTY_EN
        q_high.push_back(high_cnt);
`else
        q_high.push_back(0);
`endif
      end
      have_last = 1;
      last_rise = cyc;
      high_cnt  = 0;
    end
    if (sig_in) high_cnt++;
    pin_prev = sig_in;
    cyc++;
  end

  always @(negedge clk) begin
    if (rstn && valid) begin
      if (q_per.size() == 0) begin
        check("spurious_valid", valid, 0);
      end else begin
        int ep, eh;
        ep = q_per.pop_front();
        eh = q_high.pop_front();
        $display("valid: period=%0d high_time=%0d ovf=%0d (model %0d/%0d)", period, high_time, ovf, ep, eh);
        check("period", period, ep);
        check("high_time", high_time, eh);
        check("ovf_on_valid", ovf, 0);
        last_period = ep;
      end
    end
  end

  task automatic pulse(input int hi, input int lo);
    sig_in = 1'b1;
    repeat (hi) @(negedge clk);
    sig_in = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; en = 1'b0; sig_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_period", period, 0);
    check("rst_high_time", high_time, 0);
    check("rst_valid", valid, 0);
    check("rst_ovf", ovf, 0);
    rstn = 1'b1;
    @(negedge clk);
    en = 1'b1;
    repeat (3) @(negedge clk);

    repeat (5) pulse(1, 15);
    repeat (4) pulse(5, 5);
    repeat (3) pulse(11, 1);
    pulse(2, 10);

    // Asynchronous reset in the middle of a measurement.
    rstn = 1'b0;
    #1;
    check("midrst_period", period, 0);
    check("midrst_high_time", high_time, 0);
    check("midrst_valid", valid, 0);
    check("midrst_ovf", ovf, 0);
    last_period = 0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    repeat (3) pulse(4, 16);

    // Enable dropped for three cycles mid-period.
    en = 1'b0;
    repeat (3) @(negedge clk);
    en = 1'b1;
    repeat (5) @(negedge clk);
    check("en_hold_period", period, last_period);
    repeat (3) pulse(3, 9);

    // Overflow: one rise then a long low stretch.
    pulse(1, 300);
    check("ovf_set", ovf, 1);
    check("ovf_period_hold", period, last_period);
    en = 1'b0;
    repeat (3) @(negedge clk);
    en = 1'b1;
    repeat (5) @(negedge clk);
    check("ovf_sticky_en", ovf, 1);
    pulse(3, 17);
    pulse(3, 17);
    check("ovf_cleared", ovf, 0);
    check("ovf_recover_period", period, 20);

    repeat (40) pulse(int'($urandom_range(1, 20)), int'($urandom_range(1, 20)));
    repeat (20) @(negedge clk);
    check("pending_measurements", q_per.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pulse_meter.md
PULSE_METER -- requirements
Module: pulse_meter

Interface
REQ-001 Parameter NCntr, default 8, width of period/high-time counters and outputs.
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer depth on sig_in (legal range 2..4).
REQ-003 Port clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 Port rstn  input  1  asynchronous, active-low reset.
REQ-005 Port en  input  1  measurement enable; low forces IDLE.
REQ-006 Port sig_in  input  1  asynchronous pulse train under measurement.
REQ-007 Port period  output  NCntr  clk cycles between the last two rising edges of sig_in.
REQ-008 Port high_time  output  NCntr  clk cycles sig_in was high within that period.
REQ-009 Port valid  output  1  one-cycle strobe; period/high_time updated this cycle.
REQ-010 Port ovf  output  1  counter saturated without an edge; sticky until next valid.

Function
REQ-011 sig_in SHALL pass through SYNC_STAGES flops, then one edge-detect flop; rise/fall strobes SHALL assert SYNC_STAGES+1 cycles after the pin edge.
REQ-012 FSM states: IDLE, ARM, MEASURE.
REQ-013 IDLE -> ARM when en=1; any state -> IDLE on the cycle after en=0.
REQ-014 ARM -> MEASURE on rise strobe; cnt cleared to 1 that cycle.
REQ-015 In MEASURE cnt SHALL increment by 1 per cycle; on rise strobe period <= cnt, cnt <= 1, valid <= 1 in the following cycle.
REQ-016 Consequence: a strictly periodic sig_in of P cycles SHALL report period = P, first valid after the second rising edge.
REQ-017 hcnt SHALL increment while synchronized signal is high in MEASURE, be latched into a shadow on fall strobe, and the shadow SHALL be copied to high_time together with period.
REQ-018 Rise and fall strobes never coincide (single synchronized bit); no arbitration required.
REQ-019 If cnt reaches 2^NCntr-1 with no rise strobe: ovf <= 1, period and high_time hold, FSM -> ARM.
REQ-020 ovf SHALL clear on the next valid strobe or on reset; it SHALL NOT clear when en drops.
REQ-021 period/high_time SHALL hold last values in IDLE and ARM.
REQ-022 A signal high for the whole period (no fall strobe) SHALL report high_time = period.

Reset
REQ-023 rstn low SHALL immediately set: period=0, high_time=0, valid=0, ovf=0, FSM=IDLE, cnt=0, hcnt=0, synchronizer flops=0.
REQ-024 Reset mid-MEASURE SHALL discard the partial measurement; after release, first valid requires two fresh rising edges.

Configuration
REQ-025 Macro PULSE_METER_DUTY_EN SHALL compile in hcnt, the shadow register and high_time logic.
REQ-026 Without PULSE_METER_DUTY_EN, high_time SHALL be tied to 0 and the port SHALL remain present; period/valid/ovf behaviour unchanged.

Structure
REQ-027 Package pulse_meter_pkg SHALL hold the FSM state typedef (IDLE/ARM/MEASURE) and default parameter constants.
REQ-028 Sub-module sync_edge SHALL implement the SYNC_STAGES synchronizer plus rise/fall strobe generation, instantiated once.

Verification
REQ-029 NCntr=8, sig_in = 1-cycle pulse every 16 clk -> valid every 16 cycles, period=16, high_time=1, ovf=0.
REQ-030 sig_in square wave 5 high / 5 low -> period=10, high_time=5 (0 without PULSE_METER_DUTY_EN).
REQ-031 en=1, sig_in held 0 after one rising edge -> ovf=1 at cnt=255, FSM ARM, period unchanged; next two edges 20 apart -> valid, period=20, ovf=0.
REQ-032 rstn pulsed low mid-period -> all outputs 0 at once; no valid until two rising edges after release.
REQ-033 en dropped mid-period for 3 cycles then restored -> no valid for the interrupted period, period holds, first new valid after two edges.
REQ-034 sig_in held 1 from a rising edge, next rise after 12 cycles via 1-cycle low -> period=12, high_time=11.
